// File: rtl/bt_pkg.sv
// Shared Bluetooth receive-path types and sizes.
// Imported by the receive FIFO and its helpers.
package bt_pkg;
  localparam int BT_DATA_W        = 8;
  localparam int BT_RX_FIFO_DEPTH = 16;

  typedef logic [BT_DATA_W-1:0] bt_byte_t;
endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with a one-cycle rising-edge pulse.
// Reusable for any slow asynchronous strobe.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= a_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

// File: rtl/bt_rx_fifo.sv
// FWFT byte FIFO fed by the UART receiver's avail/dout strobe.
// The avail strobe crosses from clk_div via sync_rise.
module bt_rx_fifo
  import bt_pkg::*;
#(
  parameter int DEPTH  = BT_RX_FIFO_DEPTH,
  parameter int DATA_W = BT_DATA_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avail_in,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              ovf_clr
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              push, pop, wr, ovf_set;

  sync_rise u_sync (
    .clk  (clk),
    .rst  (rst),
    .a_in (avail_in),
    .rise (push)
  );

  assign pop     = rd_en & ~empty;
  // A pop frees the slot this edge, so a full FIFO may still accept
  assign wr      = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    cnt_nxt = count;
    unique case (1'b1)
      wr && !pop: cnt_nxt = count + CNT_W'(1);
      pop && !wr: cnt_nxt = count - CNT_W'(1);
      default:    cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CNT_W'(DEPTH));
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign dout = mem[rd_ptr];
endmodule
